// File: rtl/shift_pkg.sv
// shift_pkg: shared funct codes, operation and FIFO entry types for the EX-stage shift unit.
// Build option: define SHIFT_ARITH_EN to enable SRA/SRAV; otherwise they decode as illegal.
package shift_pkg;

    localparam logic [5:0] FUNCT_SLL  = 6'h00;
    localparam logic [5:0] FUNCT_SRL  = 6'h02;
    localparam logic [5:0] FUNCT_SRA  = 6'h03;
    localparam logic [5:0] FUNCT_SLLV = 6'h04;
    localparam logic [5:0] FUNCT_SRLV = 6'h06;
    localparam logic [5:0] FUNCT_SRAV = 6'h07;

`ifdef SHIFT_ARITH_EN
    localparam bit ARITH_EN = 1'b1;
`else
    localparam bit ARITH_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        OP_LEFT    = 2'd0,
        OP_LRIGHT  = 2'd1,
        OP_ARIGHT  = 2'd2,
        OP_ILLEGAL = 2'd3
    } shift_op_t;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        illegal;
    } shift_entry_t;

endpackage

// File: rtl/shift_core.sv
// shift_core: combinational barrel shift of value by amount for the decoded operation.
// Ports: value (32b operand), amount (5b), op (shift_op_t), result (32b).
// Illegal operations pass value through unchanged.
module shift_core
    import shift_pkg::*;
(
    input  logic [31:0] value,
    input  logic [4:0]  amount,
    input  shift_op_t   op,
    output logic [31:0] result
);

    always_comb begin
        result = (op == OP_LEFT)   ? (value << amount) :
                 (op == OP_LRIGHT) ? (value >> amount) :
                 (op == OP_ARIGHT) ? 32'($signed(value) >>> amount) :
                 value;
    end

endmodule

// File: rtl/shift_exec_unit.sv
// shift_exec_unit: MIPS EX-stage shift unit with funct decode and a 2-entry result FIFO.
// Ports: clk, reset_n (async active-low), flush (sync squash);
//        in_valid/in_ready with in_funct, in_shamt, in_rs, in_rt, in_rd;
//        out_valid/out_ready with out_result, out_rd, out_illegal.
// Build option: SHIFT_ARITH_EN enables SRA/SRAV sign-fill; undefined makes them illegal.
module shift_exec_unit
    import shift_pkg::*;
#(
    parameter int DEPTH = 2
)
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  in_funct,
    input  logic [4:0]  in_shamt,
    input  logic [31:0] in_rs,
    input  logic [31:0] in_rt,
    input  logic [4:0]  in_rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [4:0]  out_rd,
    output logic        out_illegal
);

    shift_op_t    op;
    logic [4:0]   amount;
    logic [31:0]  core_result;
    shift_entry_t push_entry;
    shift_entry_t mem [2];
    logic [1:0]   count;
    logic         wr_ptr;
    logic         rd_ptr;
    logic         push;
    logic         pop;
    logic         rs_unused;

    // Only the low five bits of rs form a shift amount.
    assign rs_unused = &{1'b0, in_rs[31:5]};

    always_comb begin
        op = ((in_funct == FUNCT_SLL) || (in_funct == FUNCT_SLLV)) ? OP_LEFT :
             ((in_funct == FUNCT_SRL) || (in_funct == FUNCT_SRLV)) ? OP_LRIGHT :
             ((in_funct == FUNCT_SRA) || (in_funct == FUNCT_SRAV)) ? (ARITH_EN ? OP_ARIGHT : OP_ILLEGAL) :
             OP_ILLEGAL;
        // funct bit 2 distinguishes the variable-amount forms.
        amount = in_funct[2] ? in_rs[4:0] : in_shamt;
    end

    shift_core u_core (
        .value  (in_rt),
        .amount (amount),
        .op     (op),
        .result (core_result)
    );

    assign push_entry = '{result: core_result, rd: in_rd, illegal: (op == OP_ILLEGAL)};

    // in_ready depends only on occupancy, keeping out_ready off the input path.
    assign in_ready  = count < 2'(DEPTH);
    assign out_valid = count != 2'd0;
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready;

    assign out_result  = mem[rd_ptr].result;
    assign out_rd      = mem[rd_ptr].rd;
    assign out_illegal = mem[rd_ptr].illegal;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else if (flush) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + 2'(push) - 2'(pop);
        end
    end

endmodule

// File: tb/tb_shift_exec_unit.sv
// tb_shift_exec_unit: scoreboard bench for shift_exec_unit with directed and random stimulus.
module tb_shift_exec_unit;

    typedef struct packed {
        logic [31:0] r;
        logic [4:0]  d;
        logic        i;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  in_funct = '0;
    logic [4:0]  in_shamt = '0;
    logic [31:0] in_rs = '0;
    logic [31:0] in_rt = '0;
    logic [4:0]  in_rd = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_illegal;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    shift_exec_unit dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_funct    (in_funct),
        .in_shamt    (in_shamt),
        .in_rs       (in_rs),
        .in_rt       (in_rt),
        .in_rd       (in_rd),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_rd      (out_rd),
        .out_illegal (out_illegal)
    );

    function automatic exp_t model(input logic [5:0] f, input logic [4:0] sh,
                                   input logic [31:0] rs, input logic [31:0] rt, input logic [4:0] rd);
        int unsigned amt;
        exp_t e;
        amt = (f == 6'h04 || f == 6'h06 || f == 6'h07) ? int'(rs % 32) : int'(sh);
        e.d = rd;
        e.i = 1'b0;
        if (f == 6'h00 || f == 6'h04) e.r = rt * (32'd1 << amt);
        else if (f == 6'h02 || f == 6'h06) e.r = rt / (32'd1 << amt);
        else if (f == 6'h03 || f == 6'h07) begin
`ifdef SHIFT_ARITH_EN
            e.r = rt / (32'd1 << amt);
            if (rt[31]) e.r = e.r | ~(32'hFFFF_FFFF / (32'd1 << amt));
`else
            e.r = rt;
            e.i = 1'b1;
`endif
        end else begin
            e.r = rt;
            e.i = 1'b1;
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // One cycle of stimulus; acc reports whether the unit took the instruction.
    task automatic drive(input logic v, input logic [5:0] f, input logic [4:0] sh,
                         input logic [31:0] rs, input logic [31:0] rt, input logic [4:0] rd,
                         input logic fl, output logic acc);
        in_valid = v;
        in_funct = f;
        in_shamt = sh;
        in_rs    = rs;
        in_rt    = rt;
        in_rd    = rd;
        flush    = fl;
        @(negedge clk);
        acc = v && in_ready && !fl;
        if (acc) exp_q.push_back(model(f, sh, rs, rt, rd));
        @(posedge clk);
        #1;
        if (fl) exp_q.delete();
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic idle(input int n);
        logic a;
        for (int k = 0; k < n; k++) drive(1'b0, 6'h00, 5'd0, 32'd0, 32'd0, 5'd0, 1'b0, a);
    endtask

    // Monitor: compares the FIFO head against the scoreboard whenever it is presented.
    always @(negedge clk) begin
        if (reset_n && out_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL spurious_out: got %h/%0d/%0d expected no output", out_result, out_rd, out_illegal);
            end else begin
                if ({out_result, out_rd, out_illegal} !== exp_q[0]) begin
                    errors++;
                    $display("FAIL head: got %h/%0d/%0d expected %h/%0d/%0d", out_result, out_rd, out_illegal,
                             exp_q[0].r, exp_q[0].d, exp_q[0].i);
                end
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        logic a;
        logic [5:0] fl_tab [8];
        int w;
        fl_tab = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h3F};
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_result", out_result, 32'd0);
        check("rst_out_rd", 32'(out_rd), 32'd0);
        check("rst_out_illegal", 32'(out_illegal), 32'd0);

        out_ready = 1'b1;
        drive(1'b1, 6'h00, 5'd4, 32'd0, 32'h0000_0001, 5'd5, 1'b0, a);
        check("sll_accept", 32'(a), 32'd1);
        check("sll_latency_valid", 32'(out_valid), 32'd1);
        check("sll_result", out_result, 32'h0000_0010);
        check("sll_rd", 32'(out_rd), 32'd5);
        idle(1);

        drive(1'b1, 6'h07, 5'd0, 32'hFFFF_FF24, 32'h8000_0000, 5'd9, 1'b0, a);
`ifdef SHIFT_ARITH_EN
        check("srav_result", out_result, 32'hF800_0000);
        check("srav_illegal", 32'(out_illegal), 32'd0);
`else
        check("srav_result", out_result, 32'h8000_0000);
        check("srav_illegal", 32'(out_illegal), 32'd1);
`endif
        idle(1);

        drive(1'b1, 6'h20, 5'd3, 32'd7, 32'h1234_5678, 5'd1, 1'b0, a);
        check("add_result", out_result, 32'h1234_5678);
        check("add_illegal", 32'(out_illegal), 32'd1);
        idle(1);

        // Backpressure: two accepted, third refused, then drain in order.
        out_ready = 1'b0;
        drive(1'b1, 6'h00, 5'd1, 32'd0, 32'h0000_0003, 5'd10, 1'b0, a);
        check("bp_accept0", 32'(a), 32'd1);
        drive(1'b1, 6'h02, 5'd1, 32'd0, 32'h0000_0030, 5'd11, 1'b0, a);
        check("bp_accept1", 32'(a), 32'd1);
        drive(1'b1, 6'h04, 5'd0, 32'd2, 32'h0000_0005, 5'd12, 1'b0, a);
        check("bp_refuse2", 32'(a), 32'd0);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        idle(2);
        check("bp_drained", 32'(out_valid), 32'd0);

        // Streaming: alternating SRL 28 and SLLV 31 with no input bubbles.
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) drive(1'b1, 6'h02, 5'd28, 32'd0, 32'hF000_0000, 5'(k), 1'b0, a);
            else drive(1'b1, 6'h04, 5'd0, 32'hABCD_E01F, 32'h0000_0003, 5'(k), 1'b0, a);
            check("stream_accept", 32'(a), 32'd1);
        end
        idle(1);

        // Flush with a full FIFO and a pending input.
        out_ready = 1'b0;
        drive(1'b1, 6'h00, 5'd2, 32'd0, 32'h0000_0001, 5'd20, 1'b0, a);
        drive(1'b1, 6'h00, 5'd3, 32'd0, 32'h0000_0001, 5'd21, 1'b0, a);
        drive(1'b1, 6'h00, 5'd4, 32'd0, 32'h0000_0001, 5'd22, 1'b1, a);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        idle(2);
        check("flush_lost_input", 32'(out_valid), 32'd0);

        // Random traffic with random backpressure and occasional flushes.
        for (int k = 0; k < 400; k++) begin
            out_ready = ($urandom % 4) != 0;
            drive(($urandom % 4) != 0, fl_tab[$urandom % 8], 5'($urandom), $urandom, $urandom,
                  5'($urandom), ($urandom % 25) == 0, a);
        end

        // Asynchronous reset mid-stream.
        out_ready = 1'b0;
        drive(1'b1, 6'h02, 5'd1, 32'd0, 32'hFFFF_FFFF, 5'd30, 1'b0, a);
        drive(1'b1, 6'h02, 5'd2, 32'd0, 32'hFFFF_FFFF, 5'd31, 1'b0, a);
        check("pre_reset_valid", 32'(out_valid), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_valid", 32'(out_valid), 32'd0);
        check("async_reset_in_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        @(posedge clk);
        #1 reset_n = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 6'h06, 5'd0, 32'd8, 32'h0000_FF00, 5'd2, 1'b0, a);
        check("post_reset_result", out_result, 32'h0000_00FF);

        w = 0;
        while ((exp_q.size() != 0 || out_valid) && w < 20) begin
            idle(1);
            w++;
        end
        check("drain_timeout", 32'(w < 20), 32'd1);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shift_exec_unit.md
# shift_exec_unit

Execute-stage shift unit for the MIPS pipeline. It sits between the ID/EX pipeline register and the EX/MEM writeback path. It takes one decoded R-type shift instruction per handshake, decodes `funct`, and selects the shift amount from either `shamt` or `rs[4:0]`. It performs the shift and queues the result, tagged with its destination register, in a 2-entry output FIFO that decouples the unit from writeback stalls.

## Interface
- `DEPTH`, 2: output FIFO entries; only 2 is supported.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous squash of all queued results (branch/exception).
- `in_valid`  in  1  ID/EX presents a shift instruction.
- `in_ready`  out  1  unit can accept this cycle.
- `in_funct`  in  6  R-type funct field.
- `in_shamt`  in  5  instruction shamt field.
- `in_rs`  in  32  rs operand (variable amount source).
- `in_rt`  in  32  rt operand (value to shift).
- `in_rd`  in  5  destination register tag.
- `out_valid`  out  1  head-of-FIFO result is valid.
- `out_ready`  in  1  writeback consumes the head.
- `out_result`  out  32  shifted value.
- `out_rd`  out  5  destination tag.
- `out_illegal`  out  1  head entry had an unsupported funct.

## Operation
- Funct decode:
  - 0x00 SLL: left by `shamt`.
  - 0x02 SRL: logical right by `shamt`.
  - 0x03 SRA: arithmetic right by `shamt`.
  - 0x04 SLLV: left by `rs[4:0]`.
  - 0x06 SRLV: logical right by `rs[4:0]`.
  - 0x07 SRAV: arithmetic right by `rs[4:0]`.
  - Any other funct: result = `in_rt` unchanged, `illegal` = 1.
- Shift amount is always 5 bits; `rs[31:5]` is ignored. An amount of 0 passes `rt` through.
- Arithmetic right shift fills vacated bits with `rt[31]`. Logical shifts fill with 0.
- Accept happens when `in_valid && in_ready`. At that point {result, rd, illegal} is computed combinationally and pushed into the FIFO.
- Pop happens when `out_valid && out_ready`, which advances the head.
- FIFO bookkeeping: `count` 0..2, `wr_ptr`/`rd_ptr` are 1 bit and wrap modulo 2.
- `in_ready` = `count < 2`. It does not look at `out_ready`, so there is no combinational path from `out_ready` to `in_ready`.
- `out_valid` = `count != 0`. Outputs are driven directly from the storage entry at `rd_ptr`.
- Simultaneous push and pop: `count` is unchanged and both pointers advance. This is legal at count 1 only; at count 2 no push is accepted.
- `flush`:
  - Next cycle `count` = 0 and both pointers = 0.
  - A push in the same cycle as `flush` is discarded.
  - A pop in the same cycle is still counted as consumed by writeback.
- `rd` = 0 is not special-cased. Writeback discards it.

## Timing
- Reset state: `count` = 0 and both pointers = 0, so `in_ready` = 1 and `out_valid` = 0. `out_result`, `out_rd` and `out_illegal` read 0 because storage resets to 0.
- Latency is 1 cycle: a result accepted at edge N is visible with `out_valid` = 1 after edge N.
- Throughput is 1 result per cycle while `out_ready` is held high.
- An asynchronous reset during any operation drops all entries immediately. No partial state survives.
- Outputs stay stable while `out_valid && !out_ready`.

## Configuration
- `SHIFT_ARITH_EN` defined: SRA and SRAV perform sign-fill as specified above.
- `SHIFT_ARITH_EN` undefined:
  - SRA and SRAV are decoded as illegal: result = `rt`, `out_illegal` = 1.
  - All other behaviour is unchanged.

## Structure
- Shared package `shift_pkg`:
  - funct constants `FUNCT_SLL`, `FUNCT_SRL`, `FUNCT_SRA`, `FUNCT_SLLV`, `FUNCT_SRLV`, `FUNCT_SRAV`.
  - typedef `shift_op_t` {left, logical_right, arith_right, illegal}.
  - typedef `shift_entry_t` {result[31:0], rd[4:0], illegal}.
- Sub-module `shift_core` is purely combinational: (`value`, `amount`, `shift_op_t`) → result, including the sign-fill. The top level holds the decode and the FIFO.

## Test plan
- After reset, SLL with rt = 0x0000_0001 and shamt = 4 → next cycle `out_valid` = 1, result 0x0000_0010, rd echoed.
- SRAV with rt = 0x8000_0000, rs = 0xFFFF_FF24 (amount 4) → 0xF800_0000. With `SHIFT_ARITH_EN` undefined → 0x8000_0000 and `out_illegal` = 1.
- `out_ready` held at 0 with three back-to-back valid inputs → first two accepted, `in_ready` = 0 on the third. On release, results drain in order.
- Streaming with `out_ready` = 1 and alternating SRL (0xF000_0000 >> 28 = 0x0000_000F) and SLLV by 31 → one result per cycle, with no `in_ready` bubbles.
- `flush` asserted with count = 2 and `in_valid` = 1 → next cycle `out_valid` = 0, `count` = 0, and the flushed input is lost.
- funct 0x20 (ADD) with rt = 0x1234_5678 → result 0x1234_5678, `out_illegal` = 1. `reset_n` dropped mid-stream → `out_valid` falls immediately.
